// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default build constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_STRETCH_CYCLES = 16;
  localparam int unsigned DEF_NUM_STAGES     = 3;
  localparam int unsigned DEF_STAGE_GAP      = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES rising edges.
module rst_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  output logic sync_rst
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '1;
    else       chain <= {chain[SYNC_STAGES-2:0], 1'b0};
  end

  assign sync_rst = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: stretch after synchronized release, then drop rst_out one bit per gap.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
  parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  rst_done,
  output logic                  sw_rst_ack
);

  localparam int unsigned CNT_MAX = max2(STRETCH_CYCLES, STAGE_GAP);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic                  sync_rst;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  armed_q, armed_d;

  rst_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sync_rst (sync_rst)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      armed_q   <= armed_d;
    end
  end

  // Stages release by shifting zeros in from bit 0; all-zero marks the sequence complete.
  // armed_q records that the request was seen low in RUN on the previous edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    ack_d     = 1'b0;
    armed_d   = 1'b0;
    if (sync_rst) begin
      state_d   = HOLD;
      cnt_d     = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
            rst_out_d = rst_out_q << 1;
            cnt_d     = '0;
            state_d   = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (rst_out_q == '0) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            rst_out_d = rst_out_q << 1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (armed_q && sw_rst_req) begin
            state_d   = HOLD;
            cnt_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
            ack_d     = 1'b1;
          end else begin
            armed_d = ~sw_rst_req;
          end
        end
        default: begin
          state_d   = HOLD;
          cnt_d     = '0;
          rst_out_d = '1;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  assign rst_out    = rst_out_q;
  assign rst_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters, edge-numbered from each reset release.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_rst_req;
  logic [2:0] rst_out;
  logic       rst_done;
  logic       sw_rst_ack;

  int compared   = 0;
  int mismatched = 0;
  int n          = 0;

  reset_sequencer #(
    .SYNC_STAGES    (2),
    .STRETCH_CYCLES (16),
    .NUM_STAGES     (3),
    .STAGE_GAP      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .rst_done   (rst_done),
    .sw_rst_ack (sw_rst_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // rel = edge where rst_out[0] falls; ack_edge = edge where the ack pulse is due (-1: none)
  task automatic step(input int rel, input int ack_edge);
    logic [2:0] e;
    tick();
    if      (n < rel)     e = 3'b111;
    else if (n < rel + 4) e = 3'b110;
    else if (n < rel + 8) e = 3'b100;
    else                  e = 3'b000;
    chk($sformatf("rst_out@%0d", n), rst_out, e);
    chk($sformatf("rst_done@%0d", n), 3'(rst_done), 3'(n >= rel + 9));
    chk($sformatf("sw_rst_ack@%0d", n), 3'(sw_rst_ack), 3'(n == ack_edge));
  endtask

  task automatic chk_in_reset(input string tag);
    chk({tag, "_rst_out"}, rst_out, 3'b111);
    chk({tag, "_rst_done"}, 3'(rst_done), 3'b000);
    chk({tag, "_ack"}, 3'(sw_rst_ack), 3'b000);
  endtask

  initial begin
    reset      = 1'b1;
    sw_rst_req = 1'b0;
    #1;
    chk_in_reset("por_t0");
    repeat (3) tick();
    chk_in_reset("por_held");
    @(negedge clk);
    reset = 1'b0;
    n = 0;

    // power-on release: 18/22/26, done at 27; then idle in RUN
    for (int i = 0; i < 39; i++) step(18, -1);

    // request rises into edge 40 and stays high for 100 cycles: one ack only
    sw_rst_req = 1'b1;
    for (int i = 0; i < 100; i++) step(56, 40);
    sw_rst_req = 1'b0;
    for (int i = 0; i < 3; i++) step(56, -1);

    // re-armed request accepted at edge 143
    sw_rst_req = 1'b1;
    step(159, 143);

    // pulses during HOLD (edge 149) and RELEASE (edge 162) are ignored
    for (int i = 0; i < 30; i++) begin
      sw_rst_req = ((n + 1) == 149) || ((n + 1) == 162);
      step(159, -1);
    end
    sw_rst_req = 1'b0;

    // asynchronous reset mid-cycle while in RUN
    #3;
    reset = 1'b1;
    #1;
    chk_in_reset("async_run");
    tick();
    tick();
    chk_in_reset("async_run_held");
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) step(18, -1);

    // asynchronous reset after rst_out[0] released, then a full restart
    #3;
    reset = 1'b1;
    #1;
    chk_in_reset("async_release");
    tick();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) step(18, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: deassertion synchronizer depth (legal ≥2).
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16: cycles all outputs stay asserted after sync release (legal ≥1).
REQ-003 SHALL have parameter NUM_STAGES, default 3: number of staged reset outputs (legal ≥1).
REQ-004 SHALL have parameter STAGE_GAP, default 4: cycles between successive stage releases (legal ≥1).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port sw_rst_req, input, 1: level software reset request, synchronous to clk.
REQ-008 SHALL have port rst_out, output, NUM_STAGES: active-high resets to downstream async-reset flops; bit 0 released first.
REQ-009 SHALL have port rst_done, output, 1: high when all stages are released.
REQ-010 SHALL have port sw_rst_ack, output, 1: one-cycle pulse per accepted software request.

Function
REQ-011 SHALL implement FSM states HOLD, RELEASE, RUN.
REQ-012 SHALL assert all rst_out immediately and asynchronously while reset is high, independent of clk.
REQ-013 SHALL release internal reset only after SYNC_STAGES rising edges following reset deassertion (async assert, sync deassert).
REQ-014 HOLD: all rst_out=1; stretch counter runs once sync reset is low; after STRETCH_CYCLES -> RELEASE.
REQ-015 Edge n = nth rising clk edge after reset falls; rst_out[0] SHALL fall at edge SYNC_STAGES+STRETCH_CYCLES (18 at defaults).
REQ-016 rst_out[k] SHALL fall exactly STAGE_GAP edges after rst_out[k-1] (defaults: edges 18, 22, 26).
REQ-017 Released stages SHALL stay low; no glitch or re-assertion except via reset or accepted software request.
REQ-018 SHALL enter RUN and set rst_done=1 one edge after last stage falls (edge 27 at defaults).
REQ-019 sw_rst_req SHALL be acted on only in RUN and only on a 0->1 transition seen in RUN; high level ignored otherwise.
REQ-020 On acceptance at edge A: all rst_out=1, rst_done=0, sw_rst_ack=1 for exactly one cycle, state HOLD, counters cleared.
REQ-021 Software-initiated sequence SHALL skip the synchronizer: rst_out[0] falls at A+STRETCH_CYCLES, then STAGE_GAP spacing, rst_done at A+STRETCH_CYCLES+(NUM_STAGES-1)*STAGE_GAP+1.
REQ-022 sw_rst_req held high across a sequence SHALL NOT retrigger; must be seen low in RUN before re-arming.
REQ-023 Counters SHALL be $clog2(max count+1) bits and SHALL NOT wrap during any sequence.
REQ-024 NUM_STAGES=1 SHALL go HOLD->RELEASE->RUN with no gap wait.

Reset
REQ-025 During reset: rst_out=all ones, rst_done=0, sw_rst_ack=0, state HOLD, counters 0, sync chain all ones, request edge-detector cleared.
REQ-026 Reset asserted mid-sequence or in RUN SHALL abort immediately and restart the full sequence from REQ-013 after release.

Structure
REQ-027 Package rst_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-028 SHALL instantiate one sub-module rst_sync_chain (SYNC_STAGES flops, async set by reset, shifts 0 in) providing synchronized internal reset.
REQ-029 All outputs SHALL be driven directly from flops; no combinational paths from inputs to outputs.

Verification
REQ-030 Power-on, defaults: reset high 3 cycles then low -> rst_out=3'b111 until edge 18; 3'b110 at 18, 3'b100 at 22, 3'b000 at 26; rst_done=1 at 27.
REQ-031 Async assert: reset pulsed between clock edges in RUN -> rst_out=3'b111 and rst_done=0 before next edge; full sequence repeats.
REQ-032 SW reset: sw_rst_req 0->1 at edge 40 in RUN -> sw_rst_ack high edge 40 only, rst_out=3'b111; releases at 56, 60, 64; rst_done at 65.
REQ-033 Held request: sw_rst_req held high 100 cycles -> exactly one ack; after low then high in RUN -> second ack.
REQ-034 Ignored request: sw_rst_req pulsed during HOLD/RELEASE -> no ack, release timing unchanged.
REQ-035 Reset mid-RELEASE (after rst_out[0] released) -> rst_out returns to all ones asynchronously; timing per REQ-030 restarts from new deassertion.
